// File: rtl/lcd_hex_driver_if.sv
// lcd_hex_driver_if: HD44780 parallel write bus (8-bit data, RS, RW, EN).
// The driver owns the bus through the master modport; the panel side, or a
// bench watching the pins, uses the slave modport.
interface lcd_hex_driver_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  modport master (output LCD_DATA, output LCD_RS, output LCD_RW, output LCD_EN);
  modport slave  (input  LCD_DATA, input  LCD_RS, input  LCD_RW, input  LCD_EN);
endinterface

// File: rtl/lcd_hex_driver.sv
// lcd_hex_driver: shows two 32-bit words as 8 uppercase hex characters each
// on row 0 and row 1 of a 16x2 HD44780 LCD.
// It runs the power-up wait and init commands once, then refreshes both rows
// in an endless loop. Every byte uses the same sequence:
// SETUP (1 cycle), PULSE (EN high), HOLD (EN low).
// Optional macro LCD_PAD_EN: after the hex characters of each row, write
// 8 spaces so that columns 8-15 are blank.
module lcd_hex_driver #(
  parameter int CNT_W          = 20,
  parameter int POWERUP_CYCLES = 750000,
  parameter int EN_CYCLES      = 16,
  parameter int CMD_CYCLES     = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             line1,
  input  logic [31:0]             line2,
  lcd_hex_driver_if.master        lcd,
  output logic                    init_done,
  output logic                    frame_done
);

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_ADDR1, ST_CHAR1, ST_ADDR2, ST_CHAR2
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP, PH_PULSE, PH_HOLD
  } phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap1_q, snap1_d;
  logic [31:0]      snap2_q, snap2_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             init_done_q, init_done_d;
  logic             frame_done_q, frame_done_d;
  logic             load_s;
  logic             pad_s;
`ifdef LCD_PAD_EN
  logic             pad_q, pad_d;
`endif

  // ASCII code for one hex digit, uppercase
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  // Init command for step i (function set, display on, clear, entry mode)
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h01;
      2'd3:    c = 8'h06;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Nibble shown in column i; column 0 holds the MSB nibble
  function automatic logic [3:0] nibble_at(input logic [31:0] v, input logic [2:0] i);
    logic [31:0] s;
    s = v >> {(3'd7 - i), 2'b00};
    return s[3:0];
  endfunction

  // Next-state logic for the phase/delay sequencer, the row FSM and the pin values
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    data_d       = data_q;
    rs_d         = rs_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    load_s       = 1'b0;
`ifdef LCD_PAD_EN
    pad_d        = pad_q;
`endif

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      case (phase_q)
        PH_SETUP: begin
          if (state_q == ST_PWRUP) begin
            phase_d = PH_HOLD;
            cnt_d   = CNT_W'(POWERUP_CYCLES - 1);
          end else begin
            phase_d = PH_PULSE;
            cnt_d   = CNT_W'(EN_CYCLES - 1);
          end
        end
        PH_PULSE: begin
          phase_d = PH_HOLD;
          // The clear command needs a much longer settle time than any other byte
          if (data_q == 8'h01 && !rs_q) begin
            cnt_d = CNT_W'(CLEAR_CYCLES - 1);
          end else begin
            cnt_d = CNT_W'(CMD_CYCLES - 1);
          end
        end
        PH_HOLD: begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          load_s  = 1'b1;
          case (state_q)
            ST_PWRUP: begin
              state_d = ST_INIT;
              idx_d   = 3'd0;
            end
            ST_INIT: begin
              if (idx_q[1:0] == 2'd3) begin
                state_d     = ST_ADDR1;
                idx_d       = 3'd0;
                init_done_d = 1'b1;
              end else begin
                state_d = ST_INIT;
                idx_d   = idx_q + 3'd1;
              end
            end
            ST_ADDR1: begin
              state_d = ST_CHAR1;
              idx_d   = 3'd0;
            end
            ST_CHAR1: begin
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd7) begin
`ifdef LCD_PAD_EN
                if (pad_q) begin
                  pad_d   = 1'b0;
                  state_d = ST_ADDR2;
                end else begin
                  pad_d   = 1'b1;
                  state_d = ST_CHAR1;
                end
`else
                state_d = ST_ADDR2;
`endif
              end else begin
                state_d = ST_CHAR1;
              end
            end
            ST_ADDR2: begin
              state_d = ST_CHAR2;
              idx_d   = 3'd0;
            end
            ST_CHAR2: begin
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd7) begin
`ifdef LCD_PAD_EN
                if (pad_q) begin
                  pad_d        = 1'b0;
                  state_d      = ST_ADDR1;
                  frame_done_d = 1'b1;
                end else begin
                  pad_d   = 1'b1;
                  state_d = ST_CHAR2;
                end
`else
                state_d      = ST_ADDR1;
                frame_done_d = 1'b1;
`endif
              end else begin
                state_d = ST_CHAR2;
              end
            end
            default: begin
              state_d = ST_PWRUP;
              idx_d   = 3'd0;
            end
          endcase
        end
        default: begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef LCD_PAD_EN
    pad_s = pad_d;
`else
    pad_s = 1'b0;
`endif

    // A new byte starts: capture both rows at the start of a frame, then choose the byte
    if (load_s) begin
      if (state_d == ST_ADDR1) begin
        snap1_d = line1;
        snap2_d = line2;
      end else begin
        snap1_d = snap1_q;
        snap2_d = snap2_q;
      end
      case (state_d)
        ST_INIT:  begin data_d = init_cmd(idx_d[1:0]); rs_d = 1'b0; end
        ST_ADDR1: begin data_d = 8'h80;                rs_d = 1'b0; end
        ST_CHAR1: begin
          data_d = pad_s ? 8'h20 : hex_char(nibble_at(snap1_q, idx_d));
          rs_d   = 1'b1;
        end
        ST_ADDR2: begin data_d = 8'hC0;                rs_d = 1'b0; end
        ST_CHAR2: begin
          data_d = pad_s ? 8'h20 : hex_char(nibble_at(snap2_q, idx_d));
          rs_d   = 1'b1;
        end
        default:  begin data_d = 8'h00;                rs_d = 1'b0; end
      endcase
    end else begin
      data_d = data_q;
      rs_d   = rs_q;
    end

    en_d = (phase_d == PH_PULSE);
  end

  // State and output registers; reset clears EN at once, even in the middle of a pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_PWRUP;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      snap1_q      <= 32'h0000_0000;
      snap2_q      <= 32'h0000_0000;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LCD_PAD_EN
      pad_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
`ifdef LCD_PAD_EN
      pad_q        <= pad_d;
`endif
    end
  end

  assign lcd.LCD_DATA = data_q;
  assign lcd.LCD_RS   = rs_q;
  assign lcd.LCD_RW   = 1'b0;
  assign lcd.LCD_EN   = en_q;
  assign init_done    = init_done_q;
  assign frame_done   = frame_done_q;

endmodule
